// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for the native memory bus, with a watchdog
// that completes unanswered downstream transactions with an error word.
module mem_arbiter #(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_wdata,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_wdata,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        err_valid,
  output logic        err_master,
  output logic [31:0] err_addr
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_next;
  logic          gnt, last;
  logic [CW-1:0] cnt;
  logic          grant_req, grantee, timeout, done;

  assign grant_req = m0_valid | m1_valid;
  // On a tie the master that did not win last time goes first.
  assign grantee   = (m0_valid && m1_valid) ? ~last : m1_valid;
  assign timeout   = (cnt == CW'(TIMEOUT - 1));
  assign done      = mem_ready | timeout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (grant_req) state_next = BUSY;
      BUSY: if (done)      state_next = IDLE;
      default:             state_next = IDLE;
    endcase
  end

  always_comb begin
    m0_ready = 1'b0;
    m0_rdata = '0;
    m1_ready = 1'b0;
    m1_rdata = '0;
    if (state == BUSY && done) begin
      if (gnt) begin
        m1_ready = 1'b1;
        m1_rdata = mem_ready ? mem_rdata : ERR_DATA;
      end else begin
        m0_ready = 1'b1;
        m0_rdata = mem_ready ? mem_rdata : ERR_DATA;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt        <= 1'b0;
      last       <= 1'b1;
      cnt        <= '0;
      mem_valid  <= 1'b0;
      mem_instr  <= 1'b0;
      mem_addr   <= '0;
      mem_wstrb  <= '0;
      mem_wdata  <= '0;
      err_valid  <= 1'b0;
      err_master <= 1'b0;
      err_addr   <= '0;
    end else begin
      err_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_req) begin
            mem_valid <= 1'b1;
            mem_instr <= grantee ? m1_instr : m0_instr;
            mem_addr  <= grantee ? m1_addr  : m0_addr;
            mem_wstrb <= grantee ? m1_wstrb : m0_wstrb;
            mem_wdata <= grantee ? m1_wdata : m0_wdata;
            gnt       <= grantee;
            last      <= grantee;
            cnt       <= '0;
          end
        end
        BUSY: begin
          // A real response takes precedence over an expiring watchdog.
          if (mem_ready) begin
            mem_valid <= 1'b0;
          end else if (timeout) begin
            mem_valid  <= 1'b0;
            err_valid  <= 1'b1;
            err_master <= gnt;
            err_addr   <= mem_addr;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: mem_valid <= 1'b0;
      endcase
    end
  end

endmodule
